// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// Holds the loader state encoding and the stream framing sizes.
package im_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // States in which the loader consumes stream bytes.
  function automatic logic takes_bytes(input logic [2:0] s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) ||
           (s == S_DATA)   || (s == S_CHK);
  endfunction

  // Start is honoured only when no load is in progress.
  function automatic logic can_start(input logic [2:0] s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/im_word_packer.sv
// Packs 4 stream bytes little-endian into one instruction word.
// Ports: clk, rst (async high), clr (drop partial word), byte_en/byte_data
// (accepted byte), last (4th byte this cycle), word/word_valid (registered).
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  assign last = byte_en &&
                (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // word_valid follows the 4th byte by one cycle and is not
  // affected by clr, so an issued write always completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      partial    <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last;
      if (clr) begin
        byte_cnt <= 2'd0;
        partial  <= 24'd0;
      end else if (byte_en) begin
        if (last) begin
          word     <= {byte_data, partial};
          byte_cnt <= 2'd0;
        end else begin
          unique case (byte_cnt)
            2'd0:    partial[7:0]   <= byte_data;
            2'd1:    partial[15:8]  <= byte_data;
            default: partial[23:16] <= byte_data;
          endcase
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory.
// Ports: clk, rst, start, in_valid/in_data/in_ready (byte link),
// we/wa/wd (memory write), cpu_hold, done, err (status, held until start).
module im_loader
  import im_loader_pkg::*;
#(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [INS_ADDRESS-1:0] wa,
  output logic [INS_W-1:0]       wd,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  localparam int DEPTH = 2 ** (INS_ADDRESS - 2);
  // One extra bit so a full-depth image ends without wrapping.
  localparam int IDX_W = INS_ADDRESS - 1;

  logic [2:0]       state;
  logic [15:0]      len;
  logic [IDX_W-1:0] word_idx;
  logic [7:0]       sum;

  logic        hs;
  logic        go;
  logic        data_hs;
  logic        last;
  logic [31:0] word;
  logic        word_valid;
  logic [15:0] n_len;
  logic [15:0] idx_next;

  // Ready depends on state only; no path from in_valid.
  assign in_ready = takes_bytes(state);
  assign hs       = in_valid && in_ready;
  assign go       = start && can_start(state);
  assign data_hs  = hs && (state == S_DATA);
  assign n_len    = {in_data, len[7:0]};
  assign idx_next = 16'(word_idx) + 16'd1;

  im_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (go),
    .byte_en    (data_hs),
    .byte_data  (in_data),
    .last       (last),
    .word       (word),
    .word_valid (word_valid)
  );

  assign we = word_valid;
  assign wd = INS_W'(word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= 16'd0;
      word_idx <= '0;
      sum      <= 8'd0;
      wa       <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (1'b1)
        go: begin
          state    <= S_LEN_LO;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          word_idx <= '0;
          sum      <= 8'd0;
        end
        (state == S_LEN_LO) && hs: begin
          len[7:0] <= in_data;
          state    <= S_LEN_HI;
        end
        (state == S_LEN_HI) && hs: begin
          len[15:8] <= in_data;
          if (n_len == 16'd0) begin
            state <= S_CHK;
          end else if ({1'b0, n_len} > 17'(DEPTH)) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        data_hs: begin
          sum <= sum + in_data;
          if (last) begin
            wa       <= {word_idx[INS_ADDRESS-3:0], 2'b00};
            word_idx <= word_idx + IDX_W'(1);
            if (idx_next == len) state <= S_CHK;
          end
        end
        (state == S_CHK) && hs: begin
          if (in_data == sum) begin
            state    <= S_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader.
// Reference: queue of expected memory writes and checksum computed per image.
module tb_im_loader;

  localparam int AW    = 9;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          cpu_hold;
  logic          done;
  logic          err;

  im_loader #(.INS_ADDRESS(AW), .INS_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic [31:0]   img [DEPTH+1];
  wr_t           expq [$];
  int            nwr = 0;
  logic [AW-1:0] last_wa = '0;

  always @(negedge clk) begin
    wr_t e;
    if (!rst && we) begin
      nwr++;
      last_wa = wa;
      if (expq.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = expq.pop_front();
        check("wa", 64'(wa), 64'(e.a));
        check("wd", 64'(wd), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input int maxgap,
                           output bit acc);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    if (!in_ready) begin
      in_valid = 1'b0;
      acc = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc = 1'b1;
  endtask

  // chk < 0 sends the correct checksum, otherwise chk[7:0].
  task automatic run_image(input int n, input int chk,
                           input int maxgap, input bit mid_start);
    logic [7:0] sum;
    logic [7:0] cb;
    logic [7:0] b;
    logic [15:0] n16;
    bit acc;
    bit ok;
    int w0;
    sum = 8'd0;
    n16 = 16'(n);
    expq.delete();
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        expq.push_back('{a: AW'(i * 4), d: img[i]});
        sum = sum + img[i][7:0] + img[i][15:8] +
              img[i][23:16] + img[i][31:24];
      end
    end
    w0 = nwr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_on_start", cpu_hold, 1);
    check("done_clr", done, 0);
    check("err_clr", err, 0);
    send_byte(n16[7:0], maxgap, acc);
    check("rdy_len_lo", acc, 1);
    send_byte(n16[15:8], maxgap, acc);
    check("rdy_len_hi", acc, 1);
    if (n > DEPTH) begin
      @(negedge clk);
      check("ovf_err", err, 1);
      check("ovf_rdy", in_ready, 0);
      check("ovf_hold", cpu_hold, 1);
      check("ovf_nwr", 64'(nwr - w0), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        if (mid_start && i == n / 2 && k == 1) start = 1'b1;
        send_byte(b, maxgap, acc);
        start = 1'b0;
        check("rdy_data", acc, 1);
        if (k == 3) check("we_lat", we, 1);
        else        check("we_idle", we, 0);
      end
    end
    cb = (chk < 0) ? sum : 8'(chk);
    ok = (cb == sum);
    send_byte(cb, maxgap, acc);
    check("rdy_chk", acc, 1);
    @(negedge clk);
    check("done", done, 64'(ok));
    check("err", err, 64'(!ok));
    check("hold_end", cpu_hold, 64'(!ok));
    check("rdy_end", in_ready, 0);
    check("nwr", 64'(nwr - w0), 64'(n));
    check("q_empty", 64'(expq.size()), 0);
  endtask

  initial begin
    bit acc;
    int w0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_we", we, 0);
    check("rst_wa", 64'(wa), 0);
    check("rst_wd", 64'(wd), 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    img[0] = 32'h0010_0093;
    img[1] = 32'h0020_0113;
    run_image(2, -1, 0, 1'b0);

    img[0] = 32'h0000_7033;
    run_image(1, 8'h00, 0, 1'b0);

    run_image(129, -1, 0, 1'b0);
    run_image(0, 8'h00, 0, 1'b0);
    run_image(0, 8'h01, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    run_image(DEPTH, -1, 3, 1'b1);
    check("last_wa", 64'(last_wa), 64'h1FC);

    for (int i = 0; i < 3; i++) img[i] = $urandom;
    run_image(3, 8'(int'($urandom_range(255, 0))), 2, 1'b0);

    // Reset in the middle of word 1.
    img[0] = $urandom;
    img[1] = $urandom;
    expq.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd2, 0, acc);
    send_byte(8'd0, 0, acc);
    send_byte(img[0][7:0], 0, acc);
    send_byte(img[0][15:8], 0, acc);
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", in_ready, 0);
    check("arst_we", we, 0);
    check("arst_wa", 64'(wa), 0);
    check("arst_wd", 64'(wd), 0);
    check("arst_hold", cpu_hold, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w0 = nwr;
    repeat (6) @(negedge clk);
    check("arst_nwr", 64'(nwr - w0), 0);
    run_image(2, -1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
